// File: rtl/core_bus_unit.sv
// Byte-serial bus interface unit: multi-byte little-endian read/write/push/pop
// over an 8-bit memory port with segment:offset addressing and 16-bit offset wrap.
module core_bus_unit #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_W     = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req,
  input  logic [1:0]              op,
  input  logic [1:0]              size,
  input  logic [15:0]             seg,
  input  logic [15:0]             off,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic                    busy,
  output logic                    done,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic [15:0]             sp_out,
  output logic [ADDR_W-1:0]       address,
  input  logic [7:0]              data,
  output logic [7:0]              out,
  output logic                    wren
);

  localparam int WD = 8 * DATA_BYTES;
  localparam logic [1:0] MAX_SIZE = 2'(DATA_BYTES - 1);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t          state_q;
  logic            is_wr_q;
  logic            prime_q;
  logic [2:0]      n_q;
  logic [2:0]      a_q;
  logic [2:0]      k_q;
  logic [15:0]     seg_q;
  logic [15:0]     base_q;
  logic [WD-1:0]   wdata_q;
  logic [WD-1:0]   rdata_q;
  logic [15:0]     sp_q;
  logic [ADDR_W-1:0] address_q;
  logic [7:0]      out_q;
  logic            busy_q;
  logic            done_q;
  logic            wren_q;

  logic [1:0]      size_d;
  logic [2:0]      n_d;
  logic [15:0]     base_d;
  logic [15:0]     sp_d;
  logic            is_wr_d;

  function automatic logic [ADDR_W-1:0] phys(input logic [15:0] s, input logic [15:0] o);
    logic [31:0] sum;
    sum = {12'd0, s, 4'd0} + {16'd0, o};
    return ADDR_W'(sum);
  endfunction

  function automatic logic [7:0] byte_sel(input logic [WD-1:0] w, input logic [2:0] idx);
    return 8'(w >> {idx, 3'b000});
  endfunction

  always_comb begin
    size_d  = (size > MAX_SIZE) ? MAX_SIZE : size;
    n_d     = {1'b0, size_d} + 3'd1;
    base_d  = (op == OP_PUSH) ? (off - {13'd0, n_d}) : off;
    is_wr_d = (op == OP_WRITE) || (op == OP_PUSH);
    case (op)
      OP_PUSH: sp_d = off - {13'd0, n_d};
      OP_POP:  sp_d = off + {13'd0, n_d};
      OP_READ: sp_d = sp_q;
      default: sp_d = sp_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      prime_q   <= 1'b0;
      n_q       <= 3'd0;
      a_q       <= 3'd0;
      k_q       <= 3'd0;
      seg_q     <= 16'd0;
      base_q    <= 16'd0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sp_q      <= 16'd0;
      address_q <= '0;
      out_q     <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wren_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (req) begin
            state_q   <= S_XFER;
            is_wr_q   <= is_wr_d;
            prime_q   <= 1'b1;
            n_q       <= n_d;
            a_q       <= 3'd1;
            k_q       <= 3'd0;
            seg_q     <= seg;
            base_q    <= base_d;
            wdata_q   <= wdata;
            rdata_q   <= '0;
            sp_q      <= sp_d;
            busy_q    <= 1'b1;
            address_q <= phys(seg, base_d);
            wren_q    <= is_wr_d;
            out_q     <= is_wr_d ? byte_sel(wdata, 3'd0) : out_q;
          end
        end
        S_XFER: begin
          if (a_q < n_q) begin
            address_q <= phys(seg_q, base_q + {13'd0, a_q});
            a_q       <= a_q + 3'd1;
          end
          if (is_wr_q) begin
            if (a_q < n_q) begin
              out_q <= byte_sel(wdata_q, a_q);
            end else begin
              wren_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else if (prime_q) begin
            // First edge after accept: memory has not yet returned byte 0.
            prime_q <= 1'b0;
          end else begin
            rdata_q <= rdata_q | (WD'(data) << {k_q, 3'b000});
            k_q     <= k_q + 3'd1;
            if (k_q == (n_q - 3'd1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign sp_out  = sp_q;
  assign address = address_q;
  assign out     = out_q;
  assign wren    = wren_q;

endmodule

// File: tb/tb_core_bus_unit.sv
// Directed-vector bench for core_bus_unit with a one-cycle-latency byte memory.
module tb_core_bus_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  op;
  logic [1:0]  size;
  logic [15:0] seg;
  logic [15:0] off;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic [15:0] sp_out;
  logic [19:0] address;
  logic [7:0]  data;
  logic [7:0]  out;
  logic        wren;

  logic [7:0]  mem [0:(1<<20)-1];
  logic [7:0]  mem_rd;

  int checks = 0;
  int failures = 0;

  core_bus_unit #(.DATA_BYTES(2), .ADDR_W(20)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .size(size),
    .seg(seg), .off(off), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .sp_out(sp_out), .address(address), .data(data),
    .out(out), .wren(wren)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wren) mem[address] <= out;
    mem_rd <= mem[address];
  end
  assign data = mem_rd;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic [15:0] seg;
    logic [15:0] off;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] sp;
    logic [19:0] a0;
    int          lat;
    int          wr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int lat, wrc, bsc;
    req = 1'b1; op = v.op; size = v.size; seg = v.seg; off = v.off; wdata = v.wdata;
    @(posedge clock); #1;
    req = 1'b0;
    chk($sformatf("v%0d_addr0", id), 32'(address), 32'(v.a0));
    lat = 0; wrc = 0; bsc = 0;
    while (!done && lat < 20) begin
      wrc += int'(wren);
      bsc += int'(busy);
      @(posedge clock); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_wren_cycles", id), 32'(wrc), 32'(v.wr));
    chk($sformatf("v%0d_busy_cycles", id), 32'(bsc), 32'(v.lat));
    chk($sformatf("v%0d_rdata", id), 32'(rdata), 32'(v.rdata));
    chk($sformatf("v%0d_sp_out", id), 32'(sp_out), 32'(v.sp));
    @(posedge clock); #1;
    chk($sformatf("v%0d_done_pulse", id), 32'(done), 32'd0);
    chk($sformatf("v%0d_rdata_hold", id), 32'(rdata), 32'(v.rdata));
  endtask

  initial begin
    int dc, wc, bc;
    vec_t v;
    //            op     size   seg       off       wdata     rdata     sp        a0         lat wr
    vecs[0]  = '{2'b00, 2'd1, 16'h1000, 16'h0020, 16'h0000, 16'h1234, 16'h0000, 20'h10020, 3, 0};
    vecs[1]  = '{2'b01, 2'd1, 16'h2000, 16'hFFFF, 16'hBEEF, 16'h0000, 16'h0000, 20'h2FFFF, 2, 2};
    vecs[2]  = '{2'b00, 2'd1, 16'h2000, 16'hFFFF, 16'h0000, 16'hBEEF, 16'h0000, 20'h2FFFF, 3, 0};
    vecs[3]  = '{2'b10, 2'd1, 16'h3000, 16'h0100, 16'hABCD, 16'h0000, 16'h00FE, 20'h300FE, 2, 2};
    vecs[4]  = '{2'b11, 2'd1, 16'h3000, 16'h00FE, 16'h0000, 16'hABCD, 16'h0100, 20'h300FE, 3, 0};
    vecs[5]  = '{2'b00, 2'd0, 16'h3000, 16'h00FF, 16'h0000, 16'h00AB, 16'h0100, 20'h300FF, 2, 0};
    vecs[6]  = '{2'b01, 2'd0, 16'hFFFF, 16'h0010, 16'h1177, 16'h0000, 16'h0100, 20'h00000, 1, 1};
    vecs[7]  = '{2'b00, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0077, 16'h0100, 20'h00000, 2, 0};
    vecs[8]  = '{2'b00, 2'd3, 16'h3000, 16'h00FE, 16'h0000, 16'hABCD, 16'h0100, 20'h300FE, 3, 0};
    vecs[9]  = '{2'b10, 2'd3, 16'h3000, 16'h0000, 16'h5566, 16'h0000, 16'hFFFE, 20'h3FFFE, 2, 2};
    vecs[10] = '{2'b11, 2'd1, 16'h3000, 16'hFFFE, 16'h0000, 16'h5566, 16'h0000, 20'h3FFFE, 3, 0};
    vecs[11] = '{2'b10, 2'd0, 16'h0040, 16'h0001, 16'h99AA, 16'h0000, 16'h0000, 20'h00400, 1, 1};
    vecs[12] = '{2'b00, 2'd1, 16'h0040, 16'h0000, 16'h0000, 16'h3CAA, 16'h0000, 20'h00400, 3, 0};

    mem[20'h10020] = 8'h34;
    mem[20'h10021] = 8'h12;
    mem[20'h00401] = 8'h3C;
    mem[20'h50000] = 8'h5A;
    mem[20'h50001] = 8'h5A;

    reset = 1'b1; req = 1'b0; op = 2'b00; size = 2'd0;
    seg = 16'h0; off = 16'h0; wdata = 16'h0;
    #22;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_sp_out", 32'(sp_out), 32'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    chk("mem_2FFFF", 32'(mem[20'h2FFFF]), 32'h00EF);
    chk("mem_20000", 32'(mem[20'h20000]), 32'h00BE);
    chk("mem_300FE", 32'(mem[20'h300FE]), 32'h00CD);
    chk("mem_300FF", 32'(mem[20'h300FF]), 32'h00AB);
    chk("mem_00000", 32'(mem[20'h00000]), 32'h0077);

    // Reset after the first write byte has gone out.
    req = 1'b1; op = 2'b01; size = 2'd1; seg = 16'h5000; off = 16'h0000; wdata = 16'h2211;
    @(posedge clock); #1;
    req = 1'b0;
    @(posedge clock); #1;
    chk("midrst_wren_before", 32'(wren), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_wren", 32'(wren), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_mem0", 32'(mem[20'h50000]), 32'h0011);
    chk("midrst_mem1", 32'(mem[20'h50001]), 32'h005A);
    v = '{2'b00, 2'd1, 16'h5000, 16'h0000, 16'h0000, 16'h5A11, 16'h0000, 20'h50000, 3, 0};
    run_vec(100, v);

    // req held high: one-byte writes back to back, one per done.
    req = 1'b1; op = 2'b01; size = 2'd0; seg = 16'h6000; off = 16'h0000; wdata = 16'h0042;
    dc = 0; wc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      dc += int'(done);
      wc += int'(wren);
    end
    req = 1'b0;
    @(posedge clock); #1;
    chk("b2b_done_count", 32'(dc), 32'd5);
    chk("b2b_wren_count", 32'(wc), 32'd5);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_mem", 32'(mem[20'h60000]), 32'h0042);

    // A req pulse during a read must not start anything.
    req = 1'b1; op = 2'b00; size = 2'd1; seg = 16'h1000; off = 16'h0020; wdata = 16'h0000;
    dc = 0; wc = 0; bc = 0;
    @(posedge clock); #1;
    req = 1'b0;
    bc += int'(busy); wc += int'(wren);
    @(posedge clock); #1;
    bc += int'(busy); wc += int'(wren);
    req = 1'b1; op = 2'b01; seg = 16'h7000; wdata = 16'hFFFF;
    @(posedge clock); #1;
    bc += int'(busy); wc += int'(wren);
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      dc += int'(done);
      wc += int'(wren);
      bc += int'(busy);
    end
    chk("ign_done_count", 32'(dc), 32'd1);
    chk("ign_wren_count", 32'(wc), 32'd0);
    chk("ign_busy_cycles", 32'(bc), 32'd3);
    chk("ign_rdata", 32'(rdata), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
